alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 173 +++++++++++++++++
 tb/tb_alu_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops plus a restoring shift-subtract divider.
// Optional build macro ALU_SIGNED_DIV_EN enables two's-complement division.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [13:0]      alu_control,
  input  logic [WIDTH-1:0] alu_src1,
  input  logic [WIDTH-1:0] alu_src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] div_odd
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic             accept;
  logic             is_div;
  logic             last_step;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_out;

  // rem_q: partial remainder; quo_q: dividend bits shift out as quotient bits shift in
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dsr_q;
  logic [SHW-1:0]   cnt_q;

  logic [WIDTH:0]   part;
  logic             ge;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quo_n;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dsr_mag;
  logic [WIDTH-1:0] quot_fin;
  logic [WIDTH-1:0] rem_fin;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready;
  assign is_div    = (alu_control == 14'h0008);
  assign last_step = (cnt_q == SHW'(WIDTH - 1));
  assign shamt     = alu_src1[SHW-1:0];

  // Zero or multi-hot control falls through to a zero result with normal latency
  always_comb begin
    alu_out = '0;
    if ($onehot(alu_control)) begin
      case (1'b1)
        alu_control[0]:  alu_out = alu_src1 + alu_src2;
        alu_control[1]:  alu_out = alu_src1 - alu_src2;
        alu_control[2]:  alu_out = alu_src1 * alu_src2;
        alu_control[4]:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(alu_src1) < $signed(alu_src2))};
        alu_control[5]:  alu_out = {{(WIDTH-1){1'b0}}, (alu_src1 < alu_src2)};
        alu_control[6]:  alu_out = alu_src1 & alu_src2;
        alu_control[7]:  alu_out = ~(alu_src1 | alu_src2);
        alu_control[8]:  alu_out = alu_src1 | alu_src2;
        alu_control[9]:  alu_out = alu_src1 ^ alu_src2;
        alu_control[10]: alu_out = alu_src2 << shamt;
        alu_control[11]: alu_out = alu_src2 >> shamt;
        alu_control[12]: alu_out = $signed(alu_src2) >>> shamt;
        alu_control[13]: alu_out = alu_src2 << (WIDTH / 2);
        default:         alu_out = '0;
      endcase
    end
  end

  // One restoring step; a zero divisor naturally yields all-ones quotient and remainder = dividend
  always_comb begin
    part  = {rem_q, quo_q[WIDTH-1]};
    ge    = (part >= {1'b0, dsr_q});
    diff  = part[WIDTH-1:0] - dsr_q;
    rem_n = ge ? diff : part[WIDTH-1:0];
    quo_n = {quo_q[WIDTH-2:0], ge};
  end

`ifdef ALU_SIGNED_DIV_EN
  logic             q_neg_q;
  logic             r_neg_q;
  logic             dz_q;
  logic [WIDTH-1:0] dvd_q;

  // Divide magnitudes, then restore signs; the zero-divisor case bypasses correction
  always_comb begin
    dvd_mag  = alu_src1[WIDTH-1] ? (-alu_src1) : alu_src1;
    dsr_mag  = alu_src2[WIDTH-1] ? (-alu_src2) : alu_src2;
    quot_fin = dz_q ? '1 : (q_neg_q ? (-quo_n) : quo_n);
    rem_fin  = dz_q ? dvd_q : (r_neg_q ? (-rem_n) : rem_n);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      dvd_q   <= '0;
    end else if (accept && is_div) begin
      q_neg_q <= alu_src1[WIDTH-1] ^ alu_src2[WIDTH-1];
      r_neg_q <= alu_src1[WIDTH-1];
      dz_q    <= (alu_src2 == '0);
      dvd_q   <= alu_src1;
    end
  end
`else
  always_comb begin
    dvd_mag  = alu_src1;
    dsr_mag  = alu_src2;
    quot_fin = quo_n;
    rem_fin  = rem_n;
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (accept) state_n = is_div ? S_DIV : S_DONE;
      S_DIV:   if (last_step) state_n = S_DONE;
      S_DONE:  if (out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      alu_result <= '0;
      div_odd    <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dsr_q      <= '0;
      cnt_q      <= '0;
    end else if (accept) begin
      if (is_div) begin
        rem_q <= '0;
        quo_q <= dvd_mag;
        dsr_q <= dsr_mag;
        cnt_q <= '0;
      end else begin
        alu_result <= alu_out;
        div_odd    <= '0;
      end
    end else if (state == S_DIV) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      cnt_q <= cnt_q + SHW'(1);
      if (last_step) begin
        alu_result <= quot_fin;
        div_odd    <= rem_fin;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (32-bit and 8-bit instances).
module tb_alu_seq;

  localparam logic [13:0] OP_ADD  = 14'h0001;
  localparam logic [13:0] OP_SUB  = 14'h0002;
  localparam logic [13:0] OP_MUL  = 14'h0004;
  localparam logic [13:0] OP_DIV  = 14'h0008;
  localparam logic [13:0] OP_SLT  = 14'h0010;
  localparam logic [13:0] OP_SLTU = 14'h0020;
  localparam logic [13:0] OP_AND  = 14'h0040;
  localparam logic [13:0] OP_NOR  = 14'h0080;
  localparam logic [13:0] OP_OR   = 14'h0100;
  localparam logic [13:0] OP_XOR  = 14'h0200;
  localparam logic [13:0] OP_SLL  = 14'h0400;
  localparam logic [13:0] OP_SRL  = 14'h0800;
  localparam logic [13:0] OP_SRA  = 14'h1000;
  localparam logic [13:0] OP_LUI  = 14'h2000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid, out_ready, in_ready, out_valid;
  logic [13:0] ctrl;
  logic [31:0] src1, src2, res, odd;
  logic        in_valid_8, out_ready_8, in_ready_8, out_valid_8;
  logic [13:0] ctrl_8;
  logic [7:0]  src1_8, src2_8, res_8, odd_8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) u_dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(ctrl), .alu_src1(src1), .alu_src2(src2), .out_valid(out_valid),
    .out_ready(out_ready), .alu_result(res), .div_odd(odd)
  );

  alu_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid_8), .in_ready(in_ready_8),
    .alu_control(ctrl_8), .alu_src1(src1_8), .alu_src2(src2_8), .out_valid(out_valid_8),
    .out_ready(out_ready_8), .alu_result(res_8), .div_odd(odd_8)
  );

  // Drive one request, scramble inputs after acceptance, wait (bounded) for out_valid.
  task automatic issue(input bit w8, input logic [13:0] c, input logic [31:0] a, input logic [31:0] b,
                       input bit keep, output logic [31:0] r, output logic [31:0] o, output int cyc);
    @(negedge clk);
    if (w8) begin
      in_valid_8 = 1'b1; ctrl_8 = c; src1_8 = a[7:0]; src2_8 = b[7:0];
    end else begin
      in_valid = 1'b1; ctrl = c; src1 = a; src2 = b;
    end
    @(posedge clk); #1;
    if (w8) begin
      ctrl_8 = OP_ADD; src1_8 = 8'($urandom); src2_8 = 8'($urandom);
      if (!keep) in_valid_8 = 1'b0;
    end else begin
      ctrl = OP_ADD; src1 = $urandom; src2 = $urandom;
      if (!keep) in_valid = 1'b0;
    end
    cyc = 1;
    while (!(w8 ? out_valid_8 : out_valid) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    r = w8 ? {24'b0, res_8} : res;
    o = w8 ? {24'b0, odd_8} : odd;
    in_valid   = 1'b0;
    in_valid_8 = 1'b0;
  endtask

  task automatic release_out(input bit w8);
    @(negedge clk);
    if (w8) out_ready_8 = 1'b1; else out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready   = 1'b0;
    out_ready_8 = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    total++; if (res !== 32'h0 || odd !== 32'h0) begin bad++; $display("FAIL rst_outputs: got %h/%h want 0/0", res, odd); end
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_div_backpressure();
    logic [31:0] r, o; int cyc;
    issue(1'b0, OP_DIV, 32'd564, 32'd7, 1'b0, r, o, cyc);
    total++; if (cyc != 33) begin bad++; $display("FAIL div_latency: got %0d want 33", cyc); end
    total++; if (r !== 32'd80 || o !== 32'd4) begin bad++; $display("FAIL div_564_7: got %0d r %0d want 80 r 4", r, o); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || res !== 32'd80 || odd !== 32'd4) begin
        bad++; $display("FAIL div_hold: got v=%b %0d r %0d want v=1 80 r 4", out_valid, res, odd);
      end
    end
    release_out(1'b0);
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL div_to_idle: got rdy=%b v=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_ops();
    logic [13:0] tc [16] = '{OP_ADD, OP_SUB, OP_MUL, OP_SLT, OP_SLTU, OP_AND, OP_NOR, OP_OR,
                             OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_LUI, 14'h0003, 14'h0000, 14'h0009};
    logic [31:0] ta [16] = '{32'h2223, 32'd5, 32'h10000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F01234,
                             32'hF0F01234, 32'hF0F01234, 32'hF0F01234, 32'd36, 32'd4, 32'd4,
                             32'hDEAD, 32'h2223, 32'h2223, 32'd100};
    logic [31:0] tb [16] = '{32'h2222, 32'd7, 32'h10001, 32'd1, 32'd1, 32'h0FF0FF00,
                             32'h0FF0FF00, 32'h0FF0FF00, 32'h0FF0FF00, 32'hF0000000, 32'hF0000000,
                             32'hF0000000, 32'h1234, 32'h2222, 32'h2222, 32'd7};
    logic [31:0] te [16] = '{32'h4445, 32'hFFFFFFFE, 32'h00010000, 32'd1, 32'd0, 32'h00F01200,
                             32'h000F00CB, 32'hFFF0FF34, 32'hFF00ED34, 32'h0, 32'h0F000000,
                             32'hFF000000, 32'h12340000, 32'h0, 32'h0, 32'h0};
    logic [31:0] r, o; int cyc;
    for (int i = 0; i < 16; i++) begin
      issue(1'b0, tc[i], ta[i], tb[i], 1'b0, r, o, cyc);
      total++; if (r !== te[i]) begin bad++; $display("FAIL op%0d_result ctrl=%h: got %h want %h", i, tc[i], r, te[i]); end
      total++; if (o !== 32'h0) begin bad++; $display("FAIL op%0d_div_odd: got %h want 0", i, o); end
      total++; if (cyc != 1) begin bad++; $display("FAIL op%0d_latency: got %0d want 1", i, cyc); end
      release_out(1'b0);
    end
  endtask

  task automatic test_div_special();
    logic [31:0] r, o; int cyc;
    issue(1'b0, OP_DIV, 32'd25, 32'd0, 1'b0, r, o, cyc);
    total++; if (r !== 32'hFFFFFFFF || o !== 32'd25 || cyc != 33) begin
      bad++; $display("FAIL div_by_zero: got %h r %h cyc %0d want ffffffff r 19 cyc 33", r, o, cyc);
    end
    release_out(1'b0);
`ifdef ALU_SIGNED_DIV_EN
    issue(1'b0, OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, r, o, cyc);
    total++; if (r !== 32'hFFFFFFFD || o !== 32'hFFFFFFFF) begin bad++; $display("FAIL sdiv_m7_2: got %h r %h want fffffffd r ffffffff", r, o); end
    release_out(1'b0);
    issue(1'b0, OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, r, o, cyc);
    total++; if (r !== 32'h80000000 || o !== 32'h0) begin bad++; $display("FAIL sdiv_min_m1: got %h r %h want 80000000 r 0", r, o); end
    release_out(1'b0);
    issue(1'b0, OP_DIV, 32'hFFFFFFF9, 32'd0, 1'b0, r, o, cyc);
    total++; if (r !== 32'hFFFFFFFF || o !== 32'hFFFFFFF9) begin bad++; $display("FAIL sdiv_by_zero: got %h r %h want ffffffff r fffffff9", r, o); end
    release_out(1'b0);
`else
    issue(1'b0, OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, r, o, cyc);
    total++; if (r !== 32'h7FFFFFFC || o !== 32'd1) begin bad++; $display("FAIL udiv_big_2: got %h r %h want 7ffffffc r 1", r, o); end
    release_out(1'b0);
    issue(1'b0, OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, r, o, cyc);
    total++; if (r !== 32'h0 || o !== 32'h80000000) begin bad++; $display("FAIL udiv_small_q: got %h r %h want 0 r 80000000", r, o); end
    release_out(1'b0);
`endif
    // in_valid held high with changing operands while the divide is in flight
    issue(1'b0, OP_DIV, 32'd1000, 32'd10, 1'b1, r, o, cyc);
    total++; if (r !== 32'd100 || o !== 32'd0 || cyc != 33) begin
      bad++; $display("FAIL div_ignore_inputs: got %0d r %0d cyc %0d want 100 r 0 cyc 33", r, o, cyc);
    end
    release_out(1'b0);
  endtask

  task automatic test_back_to_back();
    @(negedge clk); in_valid = 1'b1; ctrl = OP_ADD; src1 = 32'd3; src2 = 32'd4;
    @(posedge clk); #1;
    src1 = 32'd10; src2 = 32'd10;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1 || res !== 32'd7 || in_ready !== 1'b0) begin
      bad++; $display("FAIL b2b_hold: got v=%b res=%0d rdy=%b want 1/7/0", out_valid, res, in_ready);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || res !== 32'd7) begin
      bad++; $display("FAIL b2b_no_accept_in_done: got rdy=%b v=%b res=%0d want 1/0/7", in_ready, out_valid, res);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || res !== 32'd20) begin
      bad++; $display("FAIL b2b_second: got v=%b res=%0d want 1/20", out_valid, res);
    end
    release_out(1'b0);
  endtask

  task automatic test_reset_mid_div();
    logic [31:0] r, o; int cyc; bit seen;
    @(negedge clk); in_valid = 1'b1; ctrl = OP_DIV; src1 = 32'd100; src2 = 32'd3;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2; resetn = 1'b0; #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL rst_async_ctrl: got v=%b rdy=%b want 0/1", out_valid, in_ready); end
    total++; if (res !== 32'h0 || odd !== 32'h0) begin bad++; $display("FAIL rst_async_data: got %h/%h want 0/0", res, odd); end
    @(negedge clk); resetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL rst_abort: got out_valid=1 after reset want 0"); end
    issue(1'b0, OP_DIV, 32'd222, 32'd2, 1'b0, r, o, cyc);
    total++; if (r !== 32'd111 || o !== 32'd0 || cyc != 33) begin
      bad++; $display("FAIL div_after_rst: got %0d r %0d cyc %0d want 111 r 0 cyc 33", r, o, cyc);
    end
    release_out(1'b0);
  endtask

  task automatic test_width8();
    logic [13:0] tc [6] = '{OP_SLTU, OP_SLT, OP_SLTU, OP_ADD, OP_SRA, OP_DIV};
    logic [31:0] ta [6] = '{32'd1, 32'h80, 32'h80, 32'hF0, 32'd9, 32'd200};
    logic [31:0] tb [6] = '{32'd2, 32'h01, 32'h01, 32'h20, 32'h80, 32'd7};
    logic [31:0] te [6] = '{32'd1, 32'd1, 32'd0, 32'h10, 32'hC0, 32'd28};
    logic [31:0] to [6] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd4};
    int          tl [6] = '{1, 1, 1, 1, 1, 9};
    logic [31:0] r, o; int cyc;
    for (int i = 0; i < 6; i++) begin
      issue(1'b1, tc[i], ta[i], tb[i], 1'b0, r, o, cyc);
      total++;
      if (r !== te[i] || o !== to[i] || cyc != tl[i]) begin
        bad++; $display("FAIL w8_op%0d: got %h r %h cyc %0d want %h r %h cyc %0d", i, r, o, cyc, te[i], to[i], tl[i]);
      end
      release_out(1'b1);
    end
  endtask

  initial begin
    resetn = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; ctrl = '0; src1 = '0; src2 = '0;
    in_valid_8 = 1'b0; out_ready_8 = 1'b0; ctrl_8 = '0; src1_8 = '0; src2_8 = '0;
    test_reset();
    test_div_backpressure();
    test_ops();
    test_div_special();
    test_back_to_back();
    test_reset_mid_div();
    test_width8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
